// File: rtl/alu_md.sv
// alu_md: combinational ALU plus a HI/LO register pair fed by a sequential
// unsigned multiplier (shift-add) and divider (restoring), one bit per cycle.
//
// state | meaning
// IDLE  | no multi-cycle op running; MTLO/MTHI/MULTU/DIVU may be accepted
// MUL   | shift-add multiply in progress, WIDTH iterations
// DIV   | restoring divide in progress, WIDTH iterations
module alu_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    input  logic             start,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic             divz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MFLO  = 4'b0011;
    localparam logic [3:0] OP_MTLO  = 4'b0100;
    localparam logic [3:0] OP_SLTE  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MFHI  = 4'b1000;
    localparam logic [3:0] OP_MTHI  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] wk_hi_q, wk_lo_q, opb_q;
    logic             done_q, divz_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi_d, step_lo_d;

    // One iteration of the active algorithm; wk_hi holds partial product / remainder,
    // wk_lo holds the multiplier being shifted out / dividend shifting into quotient.
    always_comb begin
        mul_sum   = {1'b0, wk_hi_q} + (wk_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_shift = {wk_hi_q, wk_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // When div_ge holds the true difference is below opb_q, so WIDTH bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        step_hi_d = wk_hi_q;
        step_lo_d = wk_lo_q;
        if (state_q == MUL) begin
            step_hi_d = mul_sum[WIDTH:1];
            step_lo_d = {mul_sum[0], wk_lo_q[WIDTH-1:1]};
        end else if (state_q == DIV) begin
            step_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo_d = {wk_lo_q[WIDTH-2:0], div_ge};
        end
    end

    // Sequencer: accepts ops when idle, iterates, and commits HI/LO on the final edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            wk_hi_q <= '0;
            wk_lo_q <= '0;
            opb_q   <= '0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (ALUControl)
                            OP_MTLO: lo_q <= A;
                            OP_MTHI: hi_q <= A;
                            OP_MULTU: begin
                                wk_hi_q <= '0;
                                wk_lo_q <= A;
                                opb_q   <= B;
                                cnt_q   <= CNT_LAST;
                                divz_q  <= 1'b0;
                                state_q <= MUL;
                            end
                            OP_DIVU: begin
                                if (B == '0) begin
                                    // Divide by zero resolves immediately without entering the FSM.
                                    hi_q   <= A;
                                    lo_q   <= '1;
                                    divz_q <= 1'b1;
                                    done_q <= 1'b1;
                                end else begin
                                    wk_hi_q <= '0;
                                    wk_lo_q <= A;
                                    opb_q   <= B;
                                    cnt_q   <= CNT_LAST;
                                    divz_q  <= 1'b0;
                                    state_q <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    wk_hi_q <= step_hi_d;
                    wk_lo_q <= step_lo_d;
                    if (cnt_q == '0) begin
                        hi_q    <= step_hi_d;
                        lo_q    <= step_lo_d;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result is purely combinational and stays live while busy and during reset.
    always_comb begin
        Result = '1;
        case (ALUControl)
            OP_AND:   Result = A & B;
            OP_OR:    Result = A | B;
            OP_ADD:   Result = A + B;
            OP_SUB:   Result = A - B;
            OP_SLT:   Result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLTE:  Result = {{(WIDTH-1){1'b0}}, (A <= B)};
            OP_MFLO:  Result = lo_q;
            OP_MFHI:  Result = hi_q;
            OP_MTLO, OP_MTHI, OP_MULTU, OP_DIVU: Result = A;
            default:  Result = '1;
        endcase
    end

    assign Zero = (Result == '0);
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign divz = divz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: directed literal cases plus randomized traffic, all checked
// every cycle against a behavioural model (native multiply/divide, cycle countdown).
module tb_alu_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   op = 4'h0;
    logic         start = 1'b0;
    logic [W-1:0] Result, hi, lo;
    logic         Zero, busy, done, divz;

    alu_md #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .ALUControl(op), .start(start),
        .Result(Result), .Zero(Zero), .busy(busy), .done(done), .divz(divz),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]  m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
    logic          m_done = 1'b0, m_divz = 1'b0;
    int            m_rem = 0;
    wire  [63:0]   prod = {32'b0, A} * {32'b0, B};

    function automatic logic [W-1:0] exp_result(input logic [3:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b, input logic [W-1:0] mh,
                                                 input logic [W-1:0] ml);
        case (o)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return ml;
            4'd5:  return (a <= b) ? 1 : 0;
            4'd6:  return a - b;
            4'd7:  return (a < b) ? 1 : 0;
            4'd8:  return mh;
            4'd4, 4'd9, 4'd10, 4'd11: return a;
            default: return '1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_divz <= 1'b0; m_rem <= 0;
        end else if (m_rem != 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_hi <= pend_hi;
                m_lo <= pend_lo;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                case (op)
                    4'd4: m_lo <= A;
                    4'd9: m_hi <= A;
                    4'd10: begin
                        pend_hi <= prod[63:32];
                        pend_lo <= prod[31:0];
                        m_rem   <= W;
                        m_divz  <= 1'b0;
                    end
                    4'd11: begin
                        if (B == 0) begin
                            m_hi <= A; m_lo <= '1; m_divz <= 1'b1; m_done <= 1'b1;
                        end else begin
                            pend_lo <= A / B;
                            pend_hi <= A % B;
                            m_rem   <= W;
                            m_divz  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("result", Result, exp_result(op, A, B, m_hi, m_lo));
            chk("zero", Zero, (exp_result(op, A, B, m_hi, m_lo) == 0));
            chk("busy", busy, (m_rem != 0));
            chk("done", done, m_done);
            chk("divz", divz, m_divz);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke_mthi, output int nb, output bit ok);
        step();
        op = o; A = a; B = b; start = 1'b1;
        step();
        start = 1'b0;
        nb = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) nb++;
            if (done) begin ok = 1'b1; break; end
            if (poke_mthi) begin
                op = (i == 5) ? 4'd9 : o;
                start = (i == 5);
                A = $urandom; B = $urandom;
            end
            step();
        end
        start = 1'b0;
    endtask

    int nb, n;
    bit ok;

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        step(); step();
        chk_en = 1'b1;
        op = 4'd3; #1;
        chk("rst_mflo", Result, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_divz", divz, 0);
        reset_n = 1'b1;

        step(); op = 4'd2; A = 32'hFFFFFFFF; B = 1; #1;
        chk("add_wrap", Result, 0);
        chk("add_zero", Zero, 1);
        step(); op = 4'd6; A = 5; B = 7; #1;
        chk("sub", Result, 32'hFFFFFFFE);
        step(); op = 4'd7; A = 32'hFFFFFFFF; B = 1; #1;
        chk("slt", Result, 0);
        step(); op = 4'd5; A = 7; B = 7; #1;
        chk("slte", Result, 1);
        step(); op = 4'hF; #1;
        chk("illegal_op", Result, 32'hFFFFFFFF);

        run_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, nb, ok);
        chk("mul_done", ok, 1);
        chk("mul_busy_cycles", nb, 32);
        chk("mul_hi", hi, 32'hFFFFFFFE);
        chk("mul_lo", lo, 32'h00000001);

        run_op(4'd11, 100, 7, 1'b0, nb, ok);
        chk("div_done", ok, 1);
        chk("div_busy_cycles", nb, 32);
        chk("div_lo", lo, 14);
        chk("div_hi", hi, 2);
        chk("div_divz", divz, 0);

        step(); op = 4'd11; A = 5; B = 0; start = 1'b1;
        step(); start = 1'b0;
        chk("divz_done", done, 1);
        chk("divz_busy", busy, 0);
        chk("divz_hi", hi, 5);
        chk("divz_lo", lo, 32'hFFFFFFFF);
        chk("divz_flag", divz, 1);
        step();
        chk("divz_done_once", done, 0);
        chk("divz_busy2", busy, 0);

        step(); op = 4'd4; A = 32'h12345678; start = 1'b1;
        step(); start = 1'b0;
        chk("mtlo_lo", lo, 32'h12345678);
        chk("mtlo_hi_kept", hi, 5);
        chk("mtlo_no_done", done, 0);
        op = 4'd3; #1;
        chk("mflo", Result, 32'h12345678);

        step(); op = 4'd10; A = 3; B = 4; start = 1'b1;
        step(); start = 1'b0;
        repeat (9) step();
        reset_n = 1'b0; start = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        step();
        chk("abort_start_ignored", busy, 0);
        reset_n = 1'b1; start = 1'b0;
        run_op(4'd10, 3, 4, 1'b0, nb, ok);
        chk("mul34_done", ok, 1);
        chk("mul34_lo", lo, 32'hC);
        chk("mul34_hi", hi, 0);

        step(); op = 4'd10; A = 6; B = 7; start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) begin ok = 1'b1; break; end
        end
        chk("held_first_done", ok, 1);
        chk("held_lo", lo, 42);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (done) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        chk("held_second_done", ok, 1);
        chk("held_period", n, 33);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            step();
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(9, 11));
            start = ($urandom_range(0, 3) == 0);
            A = $urandom;
            case ($urandom_range(0, 7))
                0: B = 0;
                1: B = $urandom_range(1, 20);
                2: B = A;
                default: B = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) A = $urandom_range(0, 1000);
            reset_n = ($urandom_range(0, 299) != 0);
        end
        reset_n = 1'b1; start = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result/HI/LO width (legal: 8..64).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (2**CNT_W > WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 ALUControl  input  4  operation select.
REQ-008 start  input  1  execute strobe for MTLO/MTHI/MULTU/DIVU.
REQ-009 Result  output  WIDTH  combinational result.
REQ-010 Zero  output  1  high when Result == 0.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 done  output  1  one-cycle pulse on multi-cycle completion.
REQ-013 divz  output  1  registered, set by DIVU with B == 0, cleared by next accepted MULTU/DIVU.
REQ-014 hi, lo  output  WIDTH each  HI/LO register contents.

Function
REQ-015 Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 MFLO, 0100 MTLO, 0101 SLTE, 0110 SUB, 0111 SLT, 1000 MFHI, 1001 MTHI, 1010 MULTU, 1011 DIVU; others -> Result all ones.
REQ-016 AND/OR/ADD/SUB SHALL be combinational, modulo 2**WIDTH, carry discarded.
REQ-017 SLT/SLTE SHALL be unsigned compares, Result = 1 or 0 zero-extended.
REQ-018 MFLO/MFHI: Result = lo / hi register (pre-edge value); MTLO/MTHI/MULTU/DIVU: Result = A.
REQ-019 Combinational ops SHALL be valid in every cycle, including while busy.
REQ-020 Accept = start & ~busy & reset_n; start while busy SHALL be ignored (no queueing).
REQ-021 MTLO/MTHI accepted: lo/hi <= A at that edge; no busy, no done; the other register unchanged.
REQ-022 start with any other op SHALL have no effect.
REQ-023 FSM states IDLE, MUL, DIV; IDLE->MUL on accepted MULTU, IDLE->DIV on accepted DIVU with B != 0; MUL/DIV->IDLE after WIDTH iterations.
REQ-024 Operands SHALL be latched at accept; A/B changes while busy SHALL not affect the result.
REQ-025 MULTU: shift-add, one bit per cycle, unsigned {hi,lo} = A*B (2*WIDTH bits).
REQ-026 DIVU: restoring, one bit per cycle, lo = A / B, hi = A % B, unsigned.
REQ-027 Latency: accept at edge 0; busy = 1 after edges 0..WIDTH-1; at edge WIDTH hi/lo updated, busy -> 0, done = 1 for exactly one cycle.
REQ-028 hi/lo SHALL hold prior values until the completing edge (MFHI/MFLO during busy return old values).
REQ-029 DIVU with B == 0: no FSM entry; at accept edge hi <= A, lo <= all ones, divz <= 1, done = 1 next cycle, busy stays 0.
REQ-030 New op may be accepted in the cycle done is high (back-to-back).
REQ-031 Zero SHALL track Result combinationally in all cases.

Reset
REQ-032 reset_n low at a rising edge: state IDLE, counter 0, hi = lo = 0, busy = 0, done = 0, divz = 0.
REQ-033 Reset mid-operation SHALL abort it: no done pulse, hi/lo = 0, start ignored while reset_n low.
REQ-034 Result/Zero SHALL remain combinational during reset (MFLO/MFHI return 0).

Verification (WIDTH = 32)
REQ-035 ADD A=FFFFFFFF B=1 -> Result 0, Zero 1; SUB 5-7 -> FFFFFFFE; SLT A=FFFFFFFF B=1 -> 0; SLTE 7,7 -> 1; op 1111 -> FFFFFFFF.
REQ-036 MULTU A=FFFFFFFF B=FFFFFFFF start 1 cycle -> busy 32 cycles, done pulse, hi=FFFFFFFE lo=00000001; A/B toggled while busy have no effect.
REQ-037 DIVU A=100 B=7 -> after 32 cycles lo=14 hi=2 divz 0; then DIVU B=0 A=5 -> next cycle done, hi=5 lo=FFFFFFFF divz 1, busy never high.
REQ-038 MTLO A=12345678 start -> lo=12345678 next cycle, hi unchanged; MFLO -> 12345678; MTHI during MULTU busy -> ignored.
REQ-039 Start MULTU 3*4, assert reset_n=0 at cycle 10 -> busy 0, no done, hi=lo=0; then MULTU 3*4 -> lo=C hi=0.
REQ-040 MULTU with start held high continuously -> second op accepted in done cycle, done pulses every 33 cycles.
